// File: rtl/guess_scorer_if.sv
// Bulls-and-Cows scorer port bundle.
// Request/result signals shared by the driver and the scorer.
interface guess_scorer_if;
  logic        in_start;
  logic        in_new_game;
  logic [15:0] in_secret;
  logic [15:0] in_guess;
  logic [3:0]  out_A;
  logic [3:0]  out_B;
  logic        out_busy;
  logic        out_done;
  logic        out_err;
  logic        out_win;
  logic        out_lose;
  logic [3:0]  out_tries;

  modport master (
    output in_start, in_new_game, in_secret, in_guess,
    input  out_A, out_B, out_busy, out_done,
    input  out_err, out_win, out_lose, out_tries
  );

  modport slave (
    input  in_start, in_new_game, in_secret, in_guess,
    output out_A, out_B, out_busy, out_done,
    output out_err, out_win, out_lose, out_tries
  );
endinterface

// File: rtl/guess_scorer.sv
// Sequential Bulls-and-Cows scorer: one digit pair per cycle,
// plus guess validation, try counting and win/lose flags.
module guess_scorer #(
  parameter int unsigned MAX_TRIES = 10
) (
  input logic           clk,
  input logic           rst,
  guess_scorer_if.slave bus
);

  typedef enum logic [1:0] {IDLE, SCORE, DONE} state_t;

  localparam logic [3:0] MAX_T = 4'(MAX_TRIES);

  state_t      state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  logic [15:0] sec_q, sec_d;
  logic [15:0] gue_q, gue_d;
  logic [2:0]  a_q, a_d;
  logic [2:0]  b_q, b_d;
  logic        dup_q, dup_d;
  logic        bad_q, bad_d;
  logic [3:0]  A_q, A_d;
  logic [3:0]  B_q, B_d;
  logic        err_q, err_d;
  logic        win_q, win_d;
  logic        lose_q, lose_d;
  logic [3:0]  tries_q, tries_d;
  logic        done_q, done_d;

  logic [3:0]  gi, gj, sj;
  logic [15:0] g;

  function automatic logic [3:0] dig(
    input logic [15:0] v,
    input logic [1:0]  p
  );
    logic [15:0] sh;
    sh = v >> {p, 2'b00};
    return sh[3:0];
  endfunction

  assign gi = dig(gue_q, idx_q[3:2]);
  assign gj = dig(gue_q, idx_q[1:0]);
  assign sj = dig(sec_q, idx_q[1:0]);
  assign g  = bus.in_guess;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    sec_d   = sec_q;
    gue_d   = gue_q;
    a_d     = a_q;
    b_d     = b_q;
    dup_d   = dup_q;
    bad_d   = bad_q;
    A_d     = A_q;
    B_d     = B_q;
    err_d   = err_q;
    win_d   = win_q;
    lose_d  = lose_q;
    tries_d = tries_q;
    done_d  = 1'b0;
    // new_game aborts any state and wins over start
    if (bus.in_new_game) begin
      state_d = IDLE;
      tries_d = 4'd0;
      win_d   = 1'b0;
      lose_d  = 1'b0;
      err_d   = 1'b0;
      A_d     = 4'hF;
      B_d     = 4'hF;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.in_start && !win_q && !lose_q) begin
            sec_d   = bus.in_secret;
            gue_d   = bus.in_guess;
            a_d     = 3'd0;
            b_d     = 3'd0;
            dup_d   = 1'b0;
            idx_d   = 4'd0;
            bad_d   = (g[15:12] > 4'd9) || (g[11:8] > 4'd9)
                   || (g[7:4] > 4'd9) || (g[3:0] > 4'd9);
            state_d = SCORE;
          end
        end
        SCORE: begin
          if (gi == sj) begin
            if (idx_q[3:2] == idx_q[1:0]) a_d = a_q + 3'd1;
            else                          b_d = b_q + 3'd1;
          end
          if ((idx_q[3:2] < idx_q[1:0]) && (gi == gj)) dup_d = 1'b1;
          idx_d = idx_q + 4'd1;
          if (idx_q == 4'd15) state_d = DONE;
        end
        DONE: begin
          state_d = IDLE;
          done_d  = 1'b1;
          if (bad_q || dup_q) begin
            err_d = 1'b1;
            A_d   = 4'hF;
            B_d   = 4'hF;
          end else begin
            err_d   = 1'b0;
            A_d     = {1'b0, a_q};
            B_d     = {1'b0, b_q};
            tries_d = tries_q + 4'd1;
            win_d   = (a_q == 3'd4);
            lose_d  = (a_q != 3'd4) && (tries_q + 4'd1 == MAX_T);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= 4'd0;
      sec_q   <= 16'd0;
      gue_q   <= 16'd0;
      a_q     <= 3'd0;
      b_q     <= 3'd0;
      dup_q   <= 1'b0;
      bad_q   <= 1'b0;
      A_q     <= 4'hF;
      B_q     <= 4'hF;
      err_q   <= 1'b0;
      win_q   <= 1'b0;
      lose_q  <= 1'b0;
      tries_q <= 4'd0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      sec_q   <= sec_d;
      gue_q   <= gue_d;
      a_q     <= a_d;
      b_q     <= b_d;
      dup_q   <= dup_d;
      bad_q   <= bad_d;
      A_q     <= A_d;
      B_q     <= B_d;
      err_q   <= err_d;
      win_q   <= win_d;
      lose_q  <= lose_d;
      tries_q <= tries_d;
      done_q  <= done_d;
    end
  end

  assign bus.out_A     = A_q;
  assign bus.out_B     = B_q;
  assign bus.out_busy  = (state_q != IDLE);
  assign bus.out_done  = done_q;
  assign bus.out_err   = err_q;
  assign bus.out_win   = win_q;
  assign bus.out_lose  = lose_q;
  assign bus.out_tries = tries_q;

endmodule

// File: tb/tb_guess_scorer.sv
// Directed bench for guess_scorer with a game-level reference model
// compared against every output on every falling edge.
module tb_guess_scorer;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  guess_scorer_if bus();

  guess_scorer #(.MAX_TRIES(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;
  bit en = 1'b0;

  logic [3:0] eA, eB, eT;
  bit eErr, eWin, eLose, eBusy, eDone;

  task automatic chk(input string n, input logic [3:0] act,
                     input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
    end
  endtask

  // Bulls/cows from whole-number digit comparison
  function automatic void score(input logic [15:0] s, input logic [15:0] g,
                                output logic [3:0] a, output logic [3:0] b,
                                output bit err);
    logic [3:0] sd [4];
    logic [3:0] gd [4];
    a = 0;
    b = 0;
    err = 0;
    for (int k = 0; k < 4; k++) begin
      sd[k] = s[4*k +: 4];
      gd[k] = g[4*k +: 4];
      if (gd[k] > 9) err = 1;
    end
    for (int x = 0; x < 4; x++)
      for (int y = 0; y < 4; y++) begin
        if (x != y && gd[x] == gd[y]) err = 1;
        if (gd[x] == sd[y]) begin
          if (x == y) a++;
          else b++;
        end
      end
  endfunction

  always @(negedge clk) begin
    if (en) begin
      chk("A", bus.out_A, eA);
      chk("B", bus.out_B, eB);
      chk("tries", bus.out_tries, eT);
      chk("err", {3'b0, bus.out_err}, {3'b0, eErr});
      chk("win", {3'b0, bus.out_win}, {3'b0, eWin});
      chk("lose", {3'b0, bus.out_lose}, {3'b0, eLose});
      chk("busy", {3'b0, bus.out_busy}, {3'b0, eBusy});
      chk("done", {3'b0, bus.out_done}, {3'b0, eDone});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_exp();
    eA = 4'hF; eB = 4'hF; eT = 0;
    eErr = 0; eWin = 0; eLose = 0; eBusy = 0; eDone = 0;
  endtask

  task automatic run(input logic [15:0] s, input logic [15:0] g);
    bit ok;
    bit e;
    logic [3:0] a, b;
    bus.in_secret = s;
    bus.in_guess  = g;
    bus.in_start  = 1;
    ok = !eWin && !eLose;
    step();
    bus.in_start  = 0;
    bus.in_secret = 16'h9999;
    bus.in_guess  = 16'h0F0F;
    if (!ok) begin
      repeat (20) step();
    end else begin
      eBusy = 1;
      repeat (16) step();
      step();
      eBusy = 0;
      eDone = 1;
      score(s, g, a, b, e);
      if (e) begin
        eErr = 1; eA = 4'hF; eB = 4'hF;
      end else begin
        eErr = 0; eA = a; eB = b; eT++;
        eWin = (a == 4);
        eLose = (a != 4) && (eT == 3);
      end
      step();
      eDone = 0;
    end
  endtask

  task automatic new_game();
    bus.in_new_game = 1;
    step();
    bus.in_new_game = 0;
    clear_exp();
    step();
  endtask

  initial begin
    rst = 1;
    bus.in_start = 0;
    bus.in_new_game = 0;
    bus.in_secret = 0;
    bus.in_guess = 0;
    clear_exp();
    step();
    step();
    en = 1;
    rst = 0;
    step();

    run(16'h1234, 16'h1234);
    chk("g1_A", bus.out_A, 4'd4);
    chk("g1_B", bus.out_B, 4'd0);
    chk("g1_win", {3'b0, bus.out_win}, 4'd1);
    chk("g1_tries", bus.out_tries, 4'd1);
    run(16'h1234, 16'h4321);
    new_game();

    run(16'h1234, 16'h4321);
    chk("g2_A", bus.out_A, 4'd0);
    chk("g2_B", bus.out_B, 4'd4);
    chk("g2_err", {3'b0, bus.out_err}, 4'd0);
    run(16'h1234, 16'h5678);
    chk("g3_B", bus.out_B, 4'd0);
    chk("g3_tries", bus.out_tries, 4'd2);
    run(16'h1234, 16'h1355);
    chk("dup_err", {3'b0, bus.out_err}, 4'd1);
    chk("dup_A", bus.out_A, 4'hF);
    chk("dup_tries", bus.out_tries, 4'd2);
    run(16'h1234, 16'h12A4);
    chk("bad_err", {3'b0, bus.out_err}, 4'd1);
    run(16'h1234, 16'h5679);
    chk("lose", {3'b0, bus.out_lose}, 4'd1);
    chk("lose_tries", bus.out_tries, 4'd3);
    run(16'h1234, 16'h1234);
    new_game();
    chk("ng_tries", bus.out_tries, 4'd0);

    run(16'h1234, 16'h1243);
    chk("g4_A", bus.out_A, 4'd2);
    chk("g4_B", bus.out_B, 4'd2);
    bus.in_start = 1;
    step();
    bus.in_start = 0;
    eBusy = 1;
    repeat (7) step();
    bus.in_new_game = 1;
    step();
    bus.in_new_game = 0;
    clear_exp();
    repeat (20) step();
    chk("abort_A", bus.out_A, 4'hF);

    run(16'h5678, 16'h8765);
    bus.in_start = 1;
    step();
    bus.in_start = 0;
    eBusy = 1;
    repeat (5) step();
    rst = 1;
    step();
    rst = 0;
    clear_exp();
    step();
    chk("rst_tries", bus.out_tries, 4'd0);

    run(16'h5678, 16'h5687);
    bus.in_new_game = 1;
    bus.in_start = 1;
    step();
    bus.in_new_game = 0;
    bus.in_start = 0;
    clear_exp();
    repeat (20) step();

    en = 0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
